dsp_mac_sequencer: RTL and testbench
====================================

DSP_MAC_SEQUENCER -- requirements
Module: dsp_mac_sequencer

Interface
REQ-001 The block SHALL provide parameter TAPS, default 8, meaning the number of operand pairs accumulated per frame (range 2..255).
REQ-002 The block SHALL provide parameter PIPE_LAT, default 3, meaning the number of enabled clock edges from operands at the DSP slice inputs to the matching P at dsp_p (range 1..15).
REQ-003 CLK  input  1  single clock; all state changes on the rising edge.
REQ-004 RST  input  1  synchronous, active-high reset.
REQ-005 s_valid  input  1  operand pair valid.
REQ-006 s_ready  output  1  sequencer accepts an operand pair.
REQ-007 s_a  input  18  multiplicand, unsigned.
REQ-008 s_b  input  18  multiplier, unsigned.
REQ-009 dsp_a  output  18  to DSP slice port A.
REQ-010 dsp_b  output  18  to DSP slice port B.
REQ-011 dsp_opmode  output  8  to DSP slice OPMODE.
REQ-012 dsp_ce  output  1  common clock enable for all DSP slice CE inputs.
REQ-013 dsp_p  input  48  DSP slice P.
REQ-014 dsp_carryout  input  1  DSP slice CARRYOUT.
REQ-015 m_valid  output  1  frame result valid.
REQ-016 m_ready  input  1  result consumer ready.
REQ-017 m_data  output  48  accumulated frame result.
REQ-018 m_ovf  output  1  sticky accumulation overflow for the frame.

Function
REQ-019 FSM states SHALL be IDLE, ACC, FLUSH and OUT.
REQ-020 s_ready SHALL be 1 in IDLE and ACC and 0 in FLUSH and OUT; a beat is accepted on an edge where s_valid and s_ready are both 1.
REQ-021 dsp_a, dsp_b and dsp_opmode SHALL be combinational: on an accepting cycle they equal s_a, s_b and the tap opmode; in every other cycle they are 18'd0, 18'd0 and 8'h09.
REQ-022 Tap opmode SHALL be 8'h01 (X=M, Z=0, add, carry-in 0) for the first beat of a frame and 8'h09 (X=M, Z=P) for later beats.
REQ-023 dsp_ce SHALL be 1 on accepting cycles and in every FLUSH cycle, and 0 otherwise, so stalls freeze the slice pipeline.
REQ-024 IDLE->ACC on the first accepted beat, with tap counter set to 1 and m_ovf cleared.
REQ-025 In ACC each accepted beat SHALL increment the tap counter; the beat that makes the count equal TAPS moves the FSM to FLUSH.
REQ-026 FLUSH SHALL last exactly PIPE_LAT cycles; on the edge ending the last FLUSH cycle, m_data <= dsp_p and the FSM moves to OUT.
REQ-027 m_valid SHALL be 1 exactly in OUT; the first m_valid cycle is PIPE_LAT+1 cycles after the edge that accepted the last beat.
REQ-028 m_data and m_ovf SHALL be held stable while m_valid=1 and m_ready=0.
REQ-029 OUT->IDLE on the edge where m_ready=1; frames never overlap.
REQ-030 m_ovf SHALL be set by dsp_carryout=1 on any dsp_ce=1 cycle of the frame except the first-beat cycle, and SHALL stay set until the next frame starts.
REQ-031 s_valid gaps in ACC SHALL not change the result; the tap counter holds during gaps.

Reset
REQ-032 RST=1 at an edge SHALL force IDLE, tap and flush counters to 0, m_data=48'd0, m_ovf=0 and m_valid=0, overriding all other events in that cycle.
REQ-033 RST mid-frame SHALL abandon the partial frame with no m_valid; the next accepted beat starts a fresh frame with opmode 8'h01.
REQ-034 While RST=1, s_ready, dsp_ce and m_valid SHALL be 0.

Configuration
REQ-035 With macro DSP_MAC_SEQUENCER_SAT_EN defined, m_data SHALL be captured as 48'hFFFF_FFFF_FFFF when m_ovf would be 1 at capture; without it, m_data is always the raw dsp_p and m_ovf is still reported.

Verification
REQ-036 TAPS=4, PIPE_LAT=3, DSP slice model; back-to-back pairs (1,1),(2,3),(4,5),(6,7) -> m_data=69, m_ovf=0, m_valid first high 4 cycles after last accept.
REQ-037 Same pairs with 2 idle cycles after each -> m_data=69, dsp_ce=0 in gap cycles, opmode 8'h01 only on the first beat.
REQ-038 m_ready held 0 for 5 cycles in OUT -> m_valid, m_data and m_ovf stable, s_ready=0; first s_ready=1 in the cycle after the m_ready=1 edge.
REQ-039 RST pulsed after the 2nd beat, then pairs (3,3)x4 -> no m_valid for the aborted frame, m_data=36.
REQ-040 DSP stub drives dsp_carryout=1 on the 3rd beat cycle, dsp_p=48'h123 at capture -> m_ovf=1; m_data=48'hFFFF_FFFF_FFFF with DSP_MAC_SEQUENCER_SAT_EN, 48'h123 without.

Source files
------------

// File: rtl/dsp_mac_sequencer.sv
// dsp_mac_sequencer: feeds TAPS operand pairs per frame into an external
// multiply-accumulate DSP slice, flushes the slice pipeline, and presents
// the accumulated frame result with a valid/ready handshake.
//
// Optional feature: define DSP_MAC_SEQUENCER_SAT_EN to saturate m_data to
// all ones when the frame overflowed.  Without it m_data is the raw slice P.
//
// state | meaning
// IDLE  | waiting for the first beat of a frame
// ACC   | accepting the remaining beats, tap counter counts accepted beats
// FLUSH | slice pipeline drains for PIPE_LAT enabled cycles
// OUT   | frame result held on m_data until the consumer takes it

module dsp_mac_sequencer #(
    parameter int TAPS     = 8,
    parameter int PIPE_LAT = 3
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        s_valid,
    output logic        s_ready,
    input  logic [17:0] s_a,
    input  logic [17:0] s_b,
    output logic [17:0] dsp_a,
    output logic [17:0] dsp_b,
    output logic [7:0]  dsp_opmode,
    output logic        dsp_ce,
    input  logic [47:0] dsp_p,
    input  logic        dsp_carryout,
    output logic        m_valid,
    input  logic        m_ready,
    output logic [47:0] m_data,
    output logic        m_ovf
);

    localparam logic [7:0] TAPS_C     = 8'(TAPS);
    localparam logic [3:0] FLUSH_LOAD = 4'(PIPE_LAT - 1);
    localparam logic [7:0] OP_FIRST   = 8'h01;
    localparam logic [7:0] OP_ACC     = 8'h09;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACC   = 2'd1,
        FLUSH = 2'd2,
        OUT   = 2'd3
    } state_t;

    state_t      state;
    logic [7:0]  tap_cnt;
    logic [3:0]  flush_cnt;
    logic        accept;
    logic        in_flush;
    logic [47:0] cap_data;

    // Handshake and slice drive are combinational so the slice sees an
    // operand in the same cycle it is accepted; reset forces everything quiet.
    always_comb begin
        s_ready    = !RST && (state == IDLE || state == ACC);
        accept     = s_valid && s_ready;
        in_flush   = !RST && (state == FLUSH);
        dsp_ce     = accept || in_flush;
        dsp_a      = accept ? s_a : 18'd0;
        dsp_b      = accept ? s_b : 18'd0;
        dsp_opmode = (accept && state == IDLE) ? OP_FIRST : OP_ACC;
    end

`ifdef DSP_MAC_SEQUENCER_SAT_EN
    // Saturate when the frame overflowed, including a carry in the capture cycle.
    always_comb begin
        cap_data = (m_ovf || dsp_carryout) ? 48'hFFFF_FFFF_FFFF : dsp_p;
    end
`else
    // Raw slice result; overflow is reported only through m_ovf.
    always_comb begin
        cap_data = dsp_p;
    end
`endif

    // Frame sequencing FSM with registered result outputs.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state     <= IDLE;
            tap_cnt   <= 8'd0;
            flush_cnt <= 4'd0;
            m_data    <= 48'd0;
            m_ovf     <= 1'b0;
            m_valid   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    // The first-beat cycle never contributes to overflow.
                    if (accept) begin
                        tap_cnt <= 8'd1;
                        m_ovf   <= 1'b0;
                        state   <= ACC;
                    end
                end
                ACC: begin
                    if (accept) begin
                        if (dsp_carryout) m_ovf <= 1'b1;
                        tap_cnt <= tap_cnt + 8'd1;
                        if (tap_cnt + 8'd1 == TAPS_C) begin
                            flush_cnt <= FLUSH_LOAD;
                            state     <= FLUSH;
                        end
                    end
                end
                FLUSH: begin
                    if (dsp_carryout) m_ovf <= 1'b1;
                    if (flush_cnt == 4'd0) begin
                        m_data  <= cap_data;
                        m_valid <= 1'b1;
                        state   <= OUT;
                    end else begin
                        flush_cnt <= flush_cnt - 4'd1;
                    end
                end
                OUT: begin
                    if (m_ready) begin
                        m_valid <= 1'b0;
                        state   <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dsp_mac_sequencer.sv
// Testbench for dsp_mac_sequencer with a behavioural DSP slice stub.
// Expected frame results are computed as plain sums of products.

module tb_dsp_mac_sequencer;

    localparam int TAPS     = 4;
    localparam int PIPE_LAT = 3;

    logic        CLK = 1'b0;
    logic        RST;
    logic        s_valid;
    logic        s_ready;
    logic [17:0] s_a;
    logic [17:0] s_b;
    logic [17:0] dsp_a;
    logic [17:0] dsp_b;
    logic [7:0]  dsp_opmode;
    logic        dsp_ce;
    logic [47:0] dsp_p;
    logic        dsp_carryout;
    logic        m_valid;
    logic        m_ready;
    logic [47:0] m_data;
    logic        m_ovf;

    logic        cy;
    logic        p_force;
    logic [47:0] dl [PIPE_LAT];

    int n_checks = 0;
    int n_fail   = 0;

    typedef logic [17:0] opnd_t [TAPS];
    typedef logic [7:0]  ops_t  [TAPS];
    typedef int          gaps_t [TAPS];

    dsp_mac_sequencer #(.TAPS(TAPS), .PIPE_LAT(PIPE_LAT)) dut (
        .CLK(CLK), .RST(RST),
        .s_valid(s_valid), .s_ready(s_ready), .s_a(s_a), .s_b(s_b),
        .dsp_a(dsp_a), .dsp_b(dsp_b), .dsp_opmode(dsp_opmode), .dsp_ce(dsp_ce),
        .dsp_p(dsp_p), .dsp_carryout(dsp_carryout),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_ovf(m_ovf)
    );

    always #5 CLK = ~CLK;

    // DSP slice stub: accumulate at stage 0, then delay through the pipeline.
    always @(posedge CLK) begin
        if (dsp_ce) begin
            dl[0] <= ((dsp_opmode == 8'h01) ? 48'd0 : dl[0]) + 48'(dsp_a) * 48'(dsp_b);
            for (int i = 1; i < PIPE_LAT; i++) dl[i] <= dl[i-1];
        end
    end

    assign dsp_p        = p_force ? 48'h123 : dl[PIPE_LAT-1];
    assign dsp_carryout = cy;

    function automatic logic [47:0] expect_data(input logic [47:0] sum, input logic ovf);
`ifdef DSP_MAC_SEQUENCER_SAT_EN
        return ovf ? 48'hFFFF_FFFF_FFFF : sum;
`else
        return sum;
`endif
    endfunction

    task automatic beat(input logic [17:0] a, input logic [17:0] b, input logic c,
                        output logic [7:0] op, output logic ce);
        s_valid = 1'b1; s_a = a; s_b = b; cy = c;
        #1;
        op = dsp_opmode; ce = dsp_ce;
        @(posedge CLK); #1;
        s_valid = 1'b0; s_a = 18'd0; s_b = 18'd0; cy = 1'b0;
    endtask

    task automatic gap(input logic c, output logic ce);
        s_valid = 1'b0; cy = c;
        #1;
        ce = dsp_ce;
        @(posedge CLK); #1;
        cy = 1'b0;
    endtask

    // Sends one frame; gaps follow beats 0..TAPS-2 only.
    task automatic send_frame(input opnd_t a, input opnd_t b, input gaps_t g,
                              input int cy_beat, input logic gap_cy,
                              output ops_t ops, output int ce_beat_bad,
                              output int ce_gap_bad);
        logic ce;
        ce_beat_bad = 0; ce_gap_bad = 0;
        for (int i = 0; i < TAPS; i++) begin
            beat(a[i], b[i], (i == cy_beat), ops[i], ce);
            if (ce !== 1'b1) ce_beat_bad++;
            if (i < TAPS - 1) begin
                for (int k = 0; k < g[i]; k++) begin
                    gap(gap_cy, ce);
                    if (ce !== 1'b0) ce_gap_bad++;
                end
            end
        end
    endtask

    task automatic wait_valid(output int edges);
        edges = 0;
        while (m_valid !== 1'b1 && edges < 40) begin
            @(posedge CLK); #1;
            edges++;
        end
    endtask

    task automatic consume();
        m_ready = 1'b1;
        @(posedge CLK); #1;
        m_ready = 1'b0;
    endtask

    function automatic logic ops_ok(input ops_t ops);
        logic ok = (ops[0] === 8'h01);
        for (int i = 1; i < TAPS; i++) if (ops[i] !== 8'h09) ok = 1'b0;
        return ok;
    endfunction

    task automatic test_reset();
        RST = 1'b1; s_valid = 1'b1;
        @(posedge CLK); @(posedge CLK); #1;
        n_checks++;
        if ({s_ready, dsp_ce, m_valid} !== 3'b000) begin
            n_fail++;
            $display("FAIL reset_quiet: ready/ce/valid=%b expected 000", {s_ready, dsp_ce, m_valid});
        end
        s_valid = 1'b0; RST = 1'b0;
        #1;
        n_checks++;
        if (m_data !== 48'd0 || m_ovf !== 1'b0 || m_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_values: data=%h ovf=%b valid=%b expected 0 0 0", m_data, m_ovf, m_valid);
        end
        n_checks++;
        if (s_ready !== 1'b1 || dsp_opmode !== 8'h09 || dsp_ce !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_idle_drive: ready=%b op=%h ce=%b expected 1 09 0", s_ready, dsp_opmode, dsp_ce);
        end
        @(posedge CLK); #1;
    endtask

    task automatic test_back_to_back();
        opnd_t a = '{18'd1, 18'd2, 18'd4, 18'd6};
        opnd_t b = '{18'd1, 18'd3, 18'd5, 18'd7};
        gaps_t g = '{0, 0, 0, 0};
        ops_t ops; int cb, cg, e;
        send_frame(a, b, g, -1, 1'b0, ops, cb, cg);
        n_checks++;
        if (!ops_ok(ops) || cb != 0) begin
            n_fail++;
            $display("FAIL b2b_opmode: ops=%h %h %h %h ce_bad=%0d expected 01 09 09 09 0", ops[0], ops[1], ops[2], ops[3], cb);
        end
        n_checks++;
        if (s_ready !== 1'b0 || dsp_ce !== 1'b1) begin
            n_fail++;
            $display("FAIL b2b_flush: ready=%b ce=%b expected 0 1", s_ready, dsp_ce);
        end
        wait_valid(e);
        n_checks++;
        if (e != PIPE_LAT || m_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL b2b_latency: edges=%0d valid=%b expected %0d 1", e, m_valid, PIPE_LAT);
        end
        n_checks++;
        if (m_data !== 48'd69 || m_ovf !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_data: data=%0d ovf=%b expected 69 0", m_data, m_ovf);
        end
        consume();
        n_checks++;
        if (s_ready !== 1'b1 || m_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_release: ready=%b valid=%b expected 1 0", s_ready, m_valid);
        end
    endtask

    task automatic test_gaps();
        opnd_t a = '{18'd1, 18'd2, 18'd4, 18'd6};
        opnd_t b = '{18'd1, 18'd3, 18'd5, 18'd7};
        gaps_t g = '{2, 2, 2, 0};
        ops_t ops; int cb, cg, e;
        send_frame(a, b, g, -1, 1'b1, ops, cb, cg);
        n_checks++;
        if (cg != 0 || cb != 0) begin
            n_fail++;
            $display("FAIL gaps_ce: gap_ce_high=%0d beat_ce_low=%0d expected 0 0", cg, cb);
        end
        n_checks++;
        if (!ops_ok(ops)) begin
            n_fail++;
            $display("FAIL gaps_opmode: ops=%h %h %h %h expected 01 09 09 09", ops[0], ops[1], ops[2], ops[3]);
        end
        wait_valid(e);
        n_checks++;
        if (m_valid !== 1'b1 || m_data !== 48'd69 || m_ovf !== 1'b0) begin
            n_fail++;
            $display("FAIL gaps_data: valid=%b data=%0d ovf=%b expected 1 69 0", m_valid, m_data, m_ovf);
        end
        consume();
    endtask

    task automatic test_backpressure();
        opnd_t a = '{18'd10, 18'd20, 18'd30, 18'd40};
        opnd_t b = '{18'd2, 18'd2, 18'd2, 18'd2};
        gaps_t g = '{0, 1, 0, 0};
        ops_t ops; int cb, cg, e, bad;
        logic [47:0] d0; logic o0;
        send_frame(a, b, g, 1, 1'b0, ops, cb, cg);
        wait_valid(e);
        d0 = m_data; o0 = m_ovf;
        n_checks++;
        if (m_valid !== 1'b1 || d0 !== expect_data(48'd200, 1'b1) || o0 !== 1'b1) begin
            n_fail++;
            $display("FAIL bp_data: valid=%b data=%h ovf=%b expected 1 %h 1", m_valid, d0, o0, expect_data(48'd200, 1'b1));
        end
        bad = 0;
        for (int k = 0; k < 5; k++) begin
            s_valid = 1'b1; s_a = 18'd5; s_b = 18'd5; cy = 1'b1;
            #1;
            if (m_valid !== 1'b1 || m_data !== d0 || m_ovf !== o0 || s_ready !== 1'b0 || dsp_ce !== 1'b0) bad++;
            @(posedge CLK); #1;
        end
        s_valid = 1'b0; cy = 1'b0;
        n_checks++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL bp_hold: unstable_cycles=%0d expected 0", bad);
        end
        m_ready = 1'b1;
        #1;
        n_checks++;
        if (s_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_ready_early: ready=%b expected 0", s_ready);
        end
        @(posedge CLK); #1;
        m_ready = 1'b0;
        n_checks++;
        if (s_ready !== 1'b1 || m_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_ready_after: ready=%b valid=%b expected 1 0", s_ready, m_valid);
        end
    endtask

    task automatic test_reset_midframe();
        opnd_t a = '{18'd3, 18'd3, 18'd3, 18'd3};
        gaps_t g = '{0, 0, 0, 0};
        ops_t ops; int cb, cg, e;
        logic [7:0] op; logic ce;
        beat(18'd100, 18'd100, 1'b0, op, ce);
        beat(18'd200, 18'd200, 1'b1, op, ce);
        RST = 1'b1; s_valid = 1'b1; s_a = 18'd9; s_b = 18'd9;
        #1;
        n_checks++;
        if ({s_ready, dsp_ce, m_valid} !== 3'b000) begin
            n_fail++;
            $display("FAIL midrst_quiet: ready/ce/valid=%b expected 000", {s_ready, dsp_ce, m_valid});
        end
        @(posedge CLK); #1;
        RST = 1'b0; s_valid = 1'b0; s_a = 18'd0; s_b = 18'd0;
        n_checks++;
        if (m_valid !== 1'b0 || m_data !== 48'd0 || m_ovf !== 1'b0) begin
            n_fail++;
            $display("FAIL midrst_values: valid=%b data=%h ovf=%b expected 0 0 0", m_valid, m_data, m_ovf);
        end
        send_frame(a, a, g, -1, 1'b0, ops, cb, cg);
        n_checks++;
        if (!ops_ok(ops)) begin
            n_fail++;
            $display("FAIL midrst_opmode: ops=%h %h %h %h expected 01 09 09 09", ops[0], ops[1], ops[2], ops[3]);
        end
        wait_valid(e);
        n_checks++;
        if (e != PIPE_LAT || m_data !== 48'd36 || m_ovf !== 1'b0) begin
            n_fail++;
            $display("FAIL midrst_data: edges=%0d data=%0d ovf=%b expected %0d 36 0", e, m_data, m_ovf, PIPE_LAT);
        end
        consume();
    endtask

    task automatic test_carryout();
        opnd_t a = '{18'd1, 18'd1, 18'd1, 18'd1};
        gaps_t g = '{0, 0, 0, 0};
        ops_t ops; int cb, cg, e;
        send_frame(a, a, g, 2, 1'b0, ops, cb, cg);
        p_force = 1'b1;
        wait_valid(e);
        p_force = 1'b0;
        n_checks++;
        if (m_valid !== 1'b1 || m_ovf !== 1'b1 || m_data !== expect_data(48'h123, 1'b1)) begin
            n_fail++;
            $display("FAIL carry_third: valid=%b ovf=%b data=%h expected 1 1 %h", m_valid, m_ovf, m_data, expect_data(48'h123, 1'b1));
        end
        consume();
        send_frame(a, a, g, 0, 1'b0, ops, cb, cg);
        wait_valid(e);
        n_checks++;
        if (m_ovf !== 1'b0 || m_data !== 48'd4) begin
            n_fail++;
            $display("FAIL carry_first_ignored: ovf=%b data=%0d expected 0 4", m_ovf, m_data);
        end
        consume();
    endtask

    task automatic test_random();
        opnd_t a, b; gaps_t g; ops_t ops;
        int cb, cg, e, cyb, hold;
        logic [47:0] sum; logic ovf;
        for (int f = 0; f < 25; f++) begin
            sum = 48'd0;
            for (int i = 0; i < TAPS; i++) begin
                a[i] = 18'($urandom);
                b[i] = 18'($urandom);
                g[i] = (i < TAPS - 1) ? int'($urandom_range(0, 2)) : 0;
                sum  = sum + 48'(a[i]) * 48'(b[i]);
            end
            cyb = int'($urandom_range(0, TAPS)) - 1;
            ovf = (cyb >= 1);
            send_frame(a, b, g, cyb, 1'($urandom), ops, cb, cg);
            wait_valid(e);
            n_checks++;
            if (e != PIPE_LAT || m_valid !== 1'b1) begin
                n_fail++;
                $display("FAIL rand_latency[%0d]: edges=%0d valid=%b expected %0d 1", f, e, m_valid, PIPE_LAT);
            end
            n_checks++;
            if (m_data !== expect_data(sum, ovf) || m_ovf !== ovf) begin
                n_fail++;
                $display("FAIL rand_data[%0d]: data=%h ovf=%b expected %h %b", f, m_data, m_ovf, expect_data(sum, ovf), ovf);
            end
            n_checks++;
            if (!ops_ok(ops) || cb != 0 || cg != 0) begin
                n_fail++;
                $display("FAIL rand_drive[%0d]: op0=%h ce_beat_bad=%0d ce_gap_bad=%0d expected 01 0 0", f, ops[0], cb, cg);
            end
            hold = int'($urandom_range(0, 3));
            for (int k = 0; k < hold; k++) begin
                @(posedge CLK); #1;
            end
            consume();
        end
    endtask

    initial begin
        RST = 1'b1; s_valid = 1'b0; s_a = 18'd0; s_b = 18'd0;
        m_ready = 1'b0; cy = 1'b0; p_force = 1'b0;
        for (int i = 0; i < PIPE_LAT; i++) dl[i] = 48'd0;
        #2;
        test_reset();
        test_back_to_back();
        test_gaps();
        test_backpressure();
        test_reset_midframe();
        test_carryout();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
